// File: rtl/rr_dist_pkg.sv
// ============================================================================
// Module   : rr_dist_pkg
// Brief    : Shared defaults and index helpers for the round-robin distributor.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rr_dist_pkg;

  localparam int DEF_NUM_OUT = 4;
  localparam int DEF_DATA_W  = 8;

  // Index width, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Compare against the last valid index so non-power-of-2 counts wrap correctly.
  function automatic int next_idx(input int cur, input int n);
    return (cur >= n - 1) ? 0 : cur + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin scan for the first ready output after last_grant.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick
  import rr_dist_pkg::*;
#(
  parameter int NUM_OUT = DEF_NUM_OUT,
  parameter int IDX_W   = idx_w(NUM_OUT)
) (
  input  logic [NUM_OUT-1:0] ready,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   pick,
  output logic               any_ready
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    pick      = '0;
    found     = 1'b0;
    cand      = last_grant;
    any_ready = |ready;
    for (int i = 0; i < NUM_OUT; i++) begin
      cand = IDX_W'(next_idx(int'(cand), NUM_OUT));
      if (!found && ready[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_distributor.sv
// ============================================================================
// Module   : rr_distributor
// Brief    : One-deep valid/ready fan-out, binding each beat to a round-robin output.
//            Optional packet lock enabled by defining RR_DIST_LOCK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_distributor
  import rr_dist_pkg::*;
#(
  parameter int NUM_OUT = DEF_NUM_OUT,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int IDX_W   = idx_w(NUM_OUT)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            io_in_valid,
  output logic                            io_in_ready,
  input  logic [DATA_W-1:0]               io_in_bits,
`ifdef RR_DIST_LOCK_EN
  input  logic                            io_in_last,
  output logic [NUM_OUT-1:0]              io_out_last,
`endif
  output logic [NUM_OUT-1:0]              io_out_valid,
  input  logic [NUM_OUT-1:0]              io_out_ready,
  output logic [NUM_OUT-1:0][DATA_W-1:0]  io_out_bits,
  output logic [IDX_W-1:0]                io_chosen
);

  logic              held_valid;
  logic [DATA_W-1:0] held_bits;
  logic [IDX_W-1:0]  held_dest;
  logic [IDX_W-1:0]  last_grant;

  logic              out_fire;
  logic              in_fire;
  logic [IDX_W-1:0]  scan_pick;
  logic              any_ready;
  logic [IDX_W-1:0]  rr_dest;
  logic [IDX_W-1:0]  dest_sel;

  rr_pick #(
    .NUM_OUT (NUM_OUT),
    .IDX_W   (IDX_W)
  ) u_pick (
    .ready      (io_out_ready),
    .last_grant (last_grant),
    .pick       (scan_pick),
    .any_ready  (any_ready)
  );

  // With no consumer ready, still advance one slot so load keeps spreading.
  assign rr_dest = any_ready ? scan_pick : IDX_W'(next_idx(int'(last_grant), NUM_OUT));

  assign out_fire    = held_valid && io_out_ready[held_dest];
  assign io_in_ready = !held_valid || out_fire;
  assign in_fire     = io_in_valid && io_in_ready;
  assign io_chosen   = held_dest;

`ifdef RR_DIST_LOCK_EN
  logic locked;
  logic held_last;

  // A packet in progress stays on the output that took its first beat.
  assign dest_sel = locked ? last_grant : rr_dest;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      locked    <= 1'b0;
      held_last <= 1'b0;
    end else if (in_fire) begin
      locked    <= !io_in_last;
      held_last <= io_in_last;
    end
  end
`else
  assign dest_sel = rr_dest;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_valid <= 1'b0;
      held_bits  <= '0;
      held_dest  <= '0;
      last_grant <= IDX_W'(NUM_OUT - 1);
    end else if (in_fire) begin
      held_valid <= 1'b1;
      held_bits  <= io_in_bits;
      held_dest  <= dest_sel;
      last_grant <= dest_sel;
    end else if (out_fire) begin
      held_valid <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    assign io_out_valid[k] = held_valid && (held_dest == IDX_W'(k));
    assign io_out_bits[k]  = held_bits;
`ifdef RR_DIST_LOCK_EN
    assign io_out_last[k]  = held_last;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_distributor.sv
// ============================================================================
// Module   : tb_rr_distributor
// Brief    : Directed self-checking bench for rr_distributor (lock test with RR_DIST_LOCK_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rr_distributor;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [7:0]          in_bits;
  logic [3:0]          out_valid;
  logic [3:0]          out_ready;
  logic [3:0][7:0]     out_bits;
  logic [1:0]          chosen;
`ifdef RR_DIST_LOCK_EN
  logic                in_last;
  logic [3:0]          out_last;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_distributor #(
    .NUM_OUT (4),
    .DATA_W  (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .io_in_valid  (in_valid),
    .io_in_ready  (in_ready),
    .io_in_bits   (in_bits),
`ifdef RR_DIST_LOCK_EN
    .io_in_last   (in_last),
    .io_out_last  (out_last),
`endif
    .io_out_valid (out_valid),
    .io_out_ready (out_ready),
    .io_out_bits  (out_bits),
    .io_chosen    (chosen)
  );

  task automatic pulse_reset;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    reset     = 1'b0;
    @(negedge clk);
    reset     = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_bits   = 8'h00;
    out_ready = 4'b1111;
`ifdef RR_DIST_LOCK_EN
    in_last   = 1'b1;
`endif
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++; $display("FAIL reset_valid got %b expected %b", out_valid, 4'b0000);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready);
    end
    checks++;
    if (chosen !== 2'd0) begin
      errors++; $display("FAIL reset_chosen got %0d expected 0", chosen);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rr_sequence;
    int exp_d[5] = '{0, 1, 2, 3, 0};
    pulse_reset();
    out_ready = 4'b1111;
    in_valid  = 1'b1;
    in_bits   = 8'h10;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL rr_in_ready beat %0d got %b expected 1", i, in_ready);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 4'(1 << exp_d[i])) begin
        errors++; $display("FAIL rr_valid beat %0d got %b expected %b", i, out_valid, 4'(1 << exp_d[i]));
      end
      checks++;
      if (out_bits[exp_d[i]] !== 8'(8'h10 + i)) begin
        errors++; $display("FAIL rr_bits beat %0d got %h expected %h", i, out_bits[exp_d[i]], 8'(8'h10 + i));
      end
      checks++;
      if (chosen !== 2'(exp_d[i])) begin
        errors++; $display("FAIL rr_chosen beat %0d got %0d expected %0d", i, chosen, exp_d[i]);
      end
      if (i < 4) in_bits = 8'(8'h11 + i);
      else       in_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++; $display("FAIL rr_drain got %b expected 0000", out_valid);
    end
  endtask

  task automatic test_pick_ready;
    pulse_reset();
    out_ready = 4'b0100;
    in_valid  = 1'b1;
    in_bits   = 8'hAA;
    @(negedge clk);
    in_valid  = 1'b0;
    checks++;
    if (out_valid !== 4'b0100) begin
      errors++; $display("FAIL pick_valid got %b expected 0100", out_valid);
    end
    checks++;
    if (out_bits[2] !== 8'hAA) begin
      errors++; $display("FAIL pick_bits got %h expected aa", out_bits[2]);
    end
    checks++;
    if (chosen !== 2'd2) begin
      errors++; $display("FAIL pick_chosen got %0d expected 2", chosen);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++; $display("FAIL pick_drain got %b expected 0000", out_valid);
    end
  endtask

  task automatic test_hold;
    pulse_reset();
    out_ready = 4'b1111;
    in_valid  = 1'b1;
    in_bits   = 8'h01;
    @(negedge clk);
    in_bits   = 8'h02;
    @(negedge clk);
    in_valid  = 1'b0;
    @(negedge clk);
    // last_grant is now 1; nothing ready so the fallback slot 2 is taken.
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_bits   = 8'h55;
    @(negedge clk);
    in_bits   = 8'h66;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) out_ready = 4'b0001;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_in_ready cycle %0d got %b expected 0", c, in_ready);
      end
      checks++;
      if (out_valid !== 4'b0100 || out_bits[2] !== 8'h55) begin
        errors++; $display("FAIL hold_beat cycle %0d got %b/%h expected 0100/55", c, out_valid, out_bits[2]);
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 4'b0100 || chosen !== 2'd2) begin
      errors++; $display("FAIL hold_stable got %b/%0d expected 0100/2", out_valid, chosen);
    end
    in_valid  = 1'b0;
    out_ready = 4'b0101;
    @(negedge clk);
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++; $display("FAIL hold_fire got %b expected 0000", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    pulse_reset();
    out_ready = 4'b1111;
    in_valid  = 1'b1;
    in_bits   = 8'h70;
    @(negedge clk);
    // Beat on output 0 fires while 0x77 loads; scan from 0 finds output 3.
    out_ready = 4'b1001;
    in_bits   = 8'h77;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_in_ready got %b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b1000 || out_bits[3] !== 8'h77 || chosen !== 2'd3) begin
      errors++; $display("FAIL b2b_reload got %b/%h/%0d expected 1000/77/3", out_valid, out_bits[3], chosen);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++; $display("FAIL b2b_drain got %b expected 0000", out_valid);
    end
  endtask

  task automatic test_async_reset;
    pulse_reset();
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_bits   = 8'h99;
    @(negedge clk);
    in_valid  = 1'b0;
    checks++;
    if (out_valid !== 4'b0001) begin
      errors++; $display("FAIL areset_pre got %b expected 0001", out_valid);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b1 || chosen !== 2'd0) begin
      errors++; $display("FAIL areset_drop got %b/%b/%0d expected 0000/1/0", out_valid, in_ready, chosen);
    end
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 4'b1111;
    in_valid  = 1'b1;
    in_bits   = 8'h3C;
    @(negedge clk);
    in_valid  = 1'b0;
    checks++;
    if (out_valid !== 4'b0001 || out_bits[0] !== 8'h3C) begin
      errors++; $display("FAIL areset_after got %b/%h expected 0001/3c", out_valid, out_bits[0]);
    end
    @(negedge clk);
  endtask

`ifdef RR_DIST_LOCK_EN
  task automatic test_lock;
    pulse_reset();
    out_ready = 4'b0010;
    in_valid  = 1'b1;
    in_bits   = 8'hB0;
    in_last   = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 4'b0010 || out_bits[1] !== 8'hB0 || out_last[1] !== 1'b0) begin
      errors++; $display("FAIL lock_b0 got %b/%h/%b expected 0010/b0/0", out_valid, out_bits[1], out_last[1]);
    end
    out_ready = 4'b1011;
    in_bits   = 8'hB1;
    @(negedge clk);
    checks++;
    if (out_valid !== 4'b0010 || out_bits[1] !== 8'hB1) begin
      errors++; $display("FAIL lock_b1 got %b/%h expected 0010/b1", out_valid, out_bits[1]);
    end
    out_ready = 4'b1101;
    in_bits   = 8'hB2;
    in_last   = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL lock_stall got %b expected 0", in_ready);
    end
    @(negedge clk);
    out_ready = 4'b0110;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 4'b0010 || out_bits[1] !== 8'hB1) begin
      errors++; $display("FAIL lock_b1_held got %b/%b/%h expected 1/0010/b1", in_ready, out_valid, out_bits[1]);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 4'b0010 || out_bits[1] !== 8'hB2 || out_last[1] !== 1'b1) begin
      errors++; $display("FAIL lock_b2 got %b/%h/%b expected 0010/b2/1", out_valid, out_bits[1], out_last[1]);
    end
    out_ready = 4'b1111;
    in_bits   = 8'hC0;
    @(negedge clk);
    in_valid  = 1'b0;
    checks++;
    if (out_valid !== 4'b0100 || out_bits[2] !== 8'hC0) begin
      errors++; $display("FAIL lock_next_pkt got %b/%h expected 0100/c0", out_valid, out_bits[2]);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++; $display("FAIL lock_drain got %b expected 0000", out_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rr_sequence();
    test_pick_ready();
    test_hold();
    test_back_to_back();
    test_async_reset();
`ifdef RR_DIST_LOCK_EN
    test_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/rr_distributor.md
Name: rr_distributor

Overview:
- Round-robin distributor with one decoupled (valid/ready) input stream and NUM_OUT decoupled output streams.
- Each accepted input beat is captured in a single holding register. A destination index is bound to the beat at capture; the beat is presented only on that output until that output accepts it.
- Sits opposite the round-robin arbiter. It fans a shared stream out to parallel consumers (e.g. worker lanes) with fair load spreading.

Parameters:
- NUM_OUT, 4, number of output ports (>=2).
- DATA_W, 8, payload width in bits.
- IDX_W, clog2(NUM_OUT) (2 at default), width of destination index.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- io_in_valid  input  1  input beat valid.
- io_in_ready  output  1  input beat accepted when valid&ready.
- io_in_bits  input  DATA_W  input payload.
- io_out_k_valid  output  1  per output k=0..NUM_OUT-1; held beat targets k.
- io_out_k_ready  input  1  per output k; consumer k can accept.
- io_out_k_bits  output  DATA_W  per output k; holding-register payload, driven identically to all k.
- io_chosen  output  IDX_W  destination index of the held beat.

Behaviour:
- State:
  - held_valid (1b)
  - held_bits (DATA_W)
  - held_dest (IDX_W)
  - last_grant (IDX_W)
- Reset (async, while reset==0):
  - held_valid=0, held_bits=0, held_dest=0.
  - last_grant=NUM_OUT-1, so the first beat targets output 0 when all outputs are ready.
  - Outputs during reset: all io_out_k_valid=0, io_in_ready=1, io_chosen=0.
- Output drive:
  - io_out_k_valid = held_valid && held_dest==k.
  - io_chosen = held_dest.
  - out_fire = held_valid && io_out_{held_dest}_ready.
- Input handshake:
  - io_in_ready = !held_valid || out_fire. This is a combinational ready path; full throughput is 1 beat/cycle.
  - in_fire = io_in_valid && io_in_ready.
- Destination pick, evaluated in the in_fire cycle:
  - Scan indices last_grant+1, last_grant+2, ... modulo NUM_OUT, wrapping.
  - The first index whose io_out_k_ready==1 is chosen.
  - If no output is ready, choose (last_grant+1) mod NUM_OUT.
  - Wrap arithmetic must be correct for non-power-of-2 NUM_OUT: compare against NUM_OUT-1 and wrap to 0, never rely on IDX_W overflow.
- Next state:
  - On in_fire: held_bits<=io_in_bits, held_dest<=pick, last_grant<=pick, held_valid<=1.
  - On out_fire without in_fire: held_valid<=0.
  - On simultaneous out_fire and in_fire: the register is reloaded and held_valid stays 1, with no bubble.
  - Otherwise: hold.
- Stability: while held_valid=1 and not fired, held_bits and held_dest must not change, even if other outputs become ready. The valid of a targeted output never drops before it fires.
- Latency: input to output is exactly 1 cycle.
- Reset asserted mid-transfer: the held beat is discarded, and last_grant returns to NUM_OUT-1.
- Input bits are ignored when io_in_valid=0.

Optional Feature:
- Macro: RR_DIST_LOCK_EN (packet lock).
- When defined:
  - Adds port io_in_last (input, 1).
  - Adds state bit locked, reset to 0.
  - in_fire with io_in_last=0 sets locked=1; in_fire with io_in_last=1 clears it.
  - While locked=1, the pick is forced to last_grant (the same output) regardless of ready, so a multi-beat packet never splits across outputs.
  - io_in_last is captured alongside bits and exported as io_out_k_last.
- When undefined: every beat is independent, and no io_in_last/io_out_k_last ports exist.

Decomposition:
- Package rr_dist_pkg:
  - Default NUM_OUT/DATA_W constants.
  - An index-width function (clog2).
  - A next-index-with-wrap function.
- One combinational sub-module, rr_pick. Inputs: ready vector and last_grant. Outputs: pick index and any_ready.
- The top level holds the registers and handshake logic.

Test Plan:
- Reset then all outputs ready; drive 5 back-to-back beats 0x10..0x14 -> accepted 1/cycle; they appear on outputs 0,1,2,3,0 one cycle after each accept; io_chosen follows 0,1,2,3,0.
- Output readies = 4'b0100, last_grant=3, beat 0xAA -> dest 2; io_out_2_valid=1 with bits 0xAA; other valids 0.
- No output ready at load, last_grant=1, beat 0x55 -> dest 2; held while io_out_2_ready=0 for 3 cycles with io_in_ready=0; raising io_out_0_ready does not move it; io_out_2_ready=1 -> fires.
- Simultaneous out_fire and new beat 0x77 -> reload with no bubble; held_valid stays 1; the new dest comes from updated round-robin order.
- Assert reset (0) while a beat is held -> all valids drop asynchronously; after release the next beat goes to output 0.
- RR_DIST_LOCK_EN: 3-beat packet (last on the 3rd beat), with only output 1 ready at first and others toggling -> all 3 beats go to the same output; the next packet moves to the next round-robin index.
